guess_register: RTL and testbench
=================================

Name: guess_register

Overview:
- Upstream stage of the feedback block. Collects the player's 4-peg guess from single-cycle button pulses and keeps a per-round history buffer.
- Drives history0..3 into the feedback block, which is combinational and returns ssd0..3.
- Samples the returned ssd0..3 to decide win, loss or next round. The game-level FSM for one game lives here.

Parameters:
- NUM_COLOURS, 6, legal peg values 0..NUM_COLOURS-1; must be ≤ 8.
- MAX_ROUNDS, 8, guesses allowed per game; must be ≤ 15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_up  in  1  one-cycle pulse: increment colour at cursor
- btn_next  in  1  one-cycle pulse: move cursor to next peg
- btn_submit  in  1  one-cycle pulse: commit current guess
- btn_review  in  1  one-cycle pulse: step through past guesses
- new_game  in  1  one-cycle pulse: restart game
- ssd0..ssd3  in  2 each  feedback returned by the feedback block (0 none, 1 colour, 2 exact)
- history0..history3  out  3 each  peg values presented to the feedback block
- cursor  out  2  peg currently being edited
- round  out  4  rounds completed, 0..MAX_ROUNDS
- review_active  out  1  history outputs show a stored row
- fb_valid  out  1  one-cycle pulse when ssd inputs were sampled
- win  out  1  level; game won
- lose  out  1  level; game lost

Behaviour:
- Reset (async, rst_n=0): state ENTRY; guess pegs g0..g3=0; cursor=0; round=0; view=0; review_active=0; fb_valid=0; win=0; lose=0; history0..3=0. History memory contents are don't-care.
- Button priority in one cycle: new_game > btn_submit > btn_up > btn_next > btn_review. Only the highest-priority pulse is acted on.
- State ENTRY:
  - btn_up: g[cursor] increments; NUM_COLOURS-1 wraps to 0.
  - btn_next: cursor increments; 3 wraps to 0.
  - btn_up and btn_next both force review_active=0.
  - btn_review:
    - If round=0: ignored.
    - If review_active=0: set review_active=1 and view=0.
    - Otherwise: view increments; when view reaches round-1, review_active returns to 0.
  - btn_submit (cycle N):
    - mem[round] <= g0..g3; review_active=0; next state CHECK.
- Output mux: history0..3 = mem[view] when review_active=1, else g0..g3. Registered mux; outputs change the cycle after the causing edge.
- State CHECK (cycle N+1): history0..3 already show g0..g3, so the feedback block settles this cycle. At the edge ending N+1:
  - Sample ssd0..3 and pulse fb_valid at N+2.
  - If ssd0..3 are all 2: win=1, state DONE.
  - Else if round=MAX_ROUNDS-1: lose=1, state DONE.
  - Else: state ENTRY, cursor=0, g0..g3 retained.
  - In all three cases round increments by 1.
- In CHECK, all buttons except new_game are ignored.
- State DONE:
  - btn_up, btn_next and btn_submit are ignored.
  - btn_review works as in ENTRY, so the player can inspect past guesses.
  - win/lose hold until new_game.
- new_game in any state: same values as reset, applied synchronously on the next edge. Takes effect even mid-CHECK; that round is not counted.
- Reset asserted mid-operation: immediate return to reset values; no partial memory write is required to be valid.
- round never exceeds MAX_ROUNDS. A submit with round=MAX_ROUNDS cannot occur, because DONE blocks it.

Decomposition:
- Shared package mastermind_pkg:
  - PEG_W=3
  - FB_NONE=0, FB_COLOUR=1, FB_EXACT=2
  - State encoding ENTRY/CHECK/DONE
  - NUM_COLOURS default
- One sub-module: guess_history_mem, MAX_ROUNDS×12-bit register file with synchronous write and registered read by view index.
- FSM, cursor and peg editing stay in guess_register.

Test Plan:
- Reset, then btn_up ×7 at cursor 0 -> history0 goes 1,2,3,4,5,0,1; history1..3 stay 0; cursor=0.
- Set guess 1,2,3,4, submit at cycle N; bench drives ssd=2,2,2,2 -> fb_valid pulse at N+2, win=1, round=1; further btn_up does not change history0..3.
- Eight submits with ssd=1,0,0,0 -> round counts 1..7 with state back to ENTRY each time; eighth submit gives lose=1, round=8, win=0.
- After 3 rounds with distinct guesses, btn_review ×3 -> history0..3 show rows 0, 1, 2, then review_active=0 and the live guess returns.
- btn_submit and btn_up in the same cycle -> submit taken, g[cursor] unchanged. btn_up during CHECK is ignored.
- rst_n pulled low during CHECK -> all outputs zero immediately. Next submit writes row 0 and round=1 after feedback.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared definitions for the guess-entry / feedback path of the mastermind game.
// Peg width, feedback codes, game state encoding and the colour-wrap helper.
package mastermind_pkg;

   localparam int PEG_W           = 3;
   localparam int NUM_COLOURS_DEF = 6;

   localparam logic [1:0] FB_NONE   = 2'd0;
   localparam logic [1:0] FB_COLOUR = 2'd1;
   localparam logic [1:0] FB_EXACT  = 2'd2;

   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_NEW    = 3'd1,
      CMD_SUBMIT = 3'd2,
      CMD_UP     = 3'd3,
      CMD_NEXT   = 3'd4,
      CMD_REVIEW = 3'd5
   } cmd_e;

   function automatic logic [PEG_W-1:0] next_colour(input logic [PEG_W-1:0] c, input int n);
      if (int'(c) >= n - 1) return '0;
      return c + PEG_W'(1);
   endfunction

endpackage

// File: rtl/guess_history_mem.sv
// Per-round guess history: one row per submitted guess, synchronous write, and a
// registered read port that selects between a stored row and the live guess.
module guess_history_mem
   import mastermind_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ROW_W = 4 * PEG_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [ROW_W-1:0] wdata_i,
   input  logic             sel_mem_i,
   input  logic [AW-1:0]    raddr_i,
   input  logic [ROW_W-1:0] live_i,
   output logic [ROW_W-1:0] row_o
);

   logic [ROW_W-1:0] mem_q [DEPTH];
   logic [ROW_W-1:0] row_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // A write only happens on submit, which also deselects the memory, so read
   // and write never target the same row on one edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) row_q <= '0;
      else          row_q <= sel_mem_i ? mem_q[raddr_i] : live_i;
   end

   assign row_o = row_q;

endmodule

// File: rtl/guess_register.sv
// Game-level controller: peg editing, submit/feedback sequencing, win/lose and
// history review. history0..3 feed the combinational feedback block; ssd0..3 return.
module guess_register
   import mastermind_pkg::*;
#(
   parameter int NUM_COLOURS = NUM_COLOURS_DEF,
   parameter int MAX_ROUNDS  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_up,
   input  logic             btn_next,
   input  logic             btn_submit,
   input  logic             btn_review,
   input  logic             new_game,
   input  logic [1:0]       ssd0,
   input  logic [1:0]       ssd1,
   input  logic [1:0]       ssd2,
   input  logic [1:0]       ssd3,
   output logic [PEG_W-1:0] history0,
   output logic [PEG_W-1:0] history1,
   output logic [PEG_W-1:0] history2,
   output logic [PEG_W-1:0] history3,
   output logic [1:0]       cursor,
   output logic [3:0]       round,
   output logic             review_active,
   output logic             fb_valid,
   output logic             win,
   output logic             lose
);

   localparam int AW    = $clog2(MAX_ROUNDS);
   localparam int ROW_W = 4 * PEG_W;

   state_e                  state_q, state_d;
   logic [3:0][PEG_W-1:0]   g_q, g_d;
   logic [1:0]              cursor_q, cursor_d;
   logic [3:0]              round_q, round_d;
   logic [3:0]              view_q, view_d;
   logic                    review_q, review_d;
   logic                    fb_valid_q, fb_valid_d;
   logic                    win_q, win_d;
   logic                    lose_q, lose_d;
   logic                    wr_en;
   logic                    rev_active_n;
   logic [3:0]              rev_view_n;
   logic [ROW_W-1:0]        row;
   cmd_e                    cmd;

   always_comb begin : p_cmd
      cmd = CMD_NONE;
      if      (new_game)   cmd = CMD_NEW;
      else if (btn_submit) cmd = CMD_SUBMIT;
      else if (btn_up)     cmd = CMD_UP;
      else if (btn_next)   cmd = CMD_NEXT;
      else if (btn_review) cmd = CMD_REVIEW;
   end

   // Review walks rows 0..round-1, then one more press returns to the live guess.
   always_comb begin : p_review
      rev_active_n = review_q;
      rev_view_n   = view_q;
      if (round_q != 4'd0) begin
         if (!review_q) begin
            rev_active_n = 1'b1;
            rev_view_n   = 4'd0;
         end else if (view_q == round_q - 4'd1) begin
            rev_active_n = 1'b0;
         end else begin
            rev_view_n = view_q + 4'd1;
         end
      end
   end

   always_comb begin : p_next
      state_d    = state_q;
      g_d        = g_q;
      cursor_d   = cursor_q;
      round_d    = round_q;
      view_d     = view_q;
      review_d   = review_q;
      fb_valid_d = 1'b0;
      win_d      = win_q;
      lose_d     = lose_q;
      wr_en      = 1'b0;
      if (cmd == CMD_NEW) begin
         state_d  = ST_ENTRY;
         g_d      = '0;
         cursor_d = 2'd0;
         round_d  = 4'd0;
         view_d   = 4'd0;
         review_d = 1'b0;
         win_d    = 1'b0;
         lose_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ENTRY: begin
               case (cmd)
                  CMD_SUBMIT: begin
                     wr_en    = 1'b1;
                     review_d = 1'b0;
                     state_d  = ST_CHECK;
                  end
                  CMD_UP: begin
                     g_d[cursor_q] = next_colour(g_q[cursor_q], NUM_COLOURS);
                     review_d      = 1'b0;
                  end
                  CMD_NEXT: begin
                     cursor_d = cursor_q + 2'd1;
                     review_d = 1'b0;
                  end
                  CMD_REVIEW: begin
                     review_d = rev_active_n;
                     view_d   = rev_view_n;
                  end
                  default: ;
               endcase
            end
            ST_CHECK: begin
               fb_valid_d = 1'b1;
               round_d    = round_q + 4'd1;
               if (ssd0 == FB_EXACT && ssd1 == FB_EXACT &&
                   ssd2 == FB_EXACT && ssd3 == FB_EXACT) begin
                  win_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (round_q == 4'(MAX_ROUNDS - 1)) begin
                  lose_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cursor_d = 2'd0;
                  state_d  = ST_ENTRY;
               end
            end
            ST_DONE: begin
               if (cmd == CMD_REVIEW) begin
                  review_d = rev_active_n;
                  view_d   = rev_view_n;
               end
            end
            default: state_d = ST_ENTRY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ENTRY;
         g_q        <= '0;
         cursor_q   <= 2'd0;
         round_q    <= 4'd0;
         view_q     <= 4'd0;
         review_q   <= 1'b0;
         fb_valid_q <= 1'b0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         cursor_q   <= cursor_d;
         round_q    <= round_d;
         view_q     <= view_d;
         review_q   <= review_d;
         fb_valid_q <= fb_valid_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
      end
   end

   guess_history_mem #(
      .DEPTH (MAX_ROUNDS),
      .ROW_W (ROW_W),
      .AW    (AW)
   ) u_mem (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .we_i      (wr_en),
      .waddr_i   (round_q[AW-1:0]),
      .wdata_i   (g_q),
      .sel_mem_i (review_d),
      .raddr_i   (view_d[AW-1:0]),
      .live_i    (g_d),
      .row_o     (row)
   );

   assign history0      = row[0*PEG_W +: PEG_W];
   assign history1      = row[1*PEG_W +: PEG_W];
   assign history2      = row[2*PEG_W +: PEG_W];
   assign history3      = row[3*PEG_W +: PEG_W];
   assign cursor        = cursor_q;
   assign round         = round_q;
   assign review_active = review_q;
   assign fb_valid      = fb_valid_q;
   assign win           = win_q;
   assign lose          = lose_q;

endmodule

// File: tb/tb_guess_register.sv
// Bench for guess_register: directed scenarios plus a random run, all compared
// against a behavioural game model kept in plain integers and arrays.
module tb_guess_register;

   localparam int NC = 6;
   localparam int MR = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0, btn_next = 1'b0, btn_submit = 1'b0, btn_review = 1'b0, new_game = 1'b0;
   logic [1:0] ssd0 = 2'd0, ssd1 = 2'd0, ssd2 = 2'd0, ssd3 = 2'd0;
   logic [2:0] history0, history1, history2, history3;
   logic [1:0] cursor;
   logic [3:0] round;
   logic       review_active, fb_valid, win, lose;
   logic [21:0] obs;

   int total = 0;
   int bad   = 0;

   // game model
   int m_g[4];
   int m_hist[16][4];
   int m_cursor, m_round, m_view;
   bit m_review, m_fb, m_win, m_lose, m_checking, m_done;

   always #5 clk = ~clk;

   guess_register #(.NUM_COLOURS(NC), .MAX_ROUNDS(MR)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_up(btn_up), .btn_next(btn_next), .btn_submit(btn_submit),
      .btn_review(btn_review), .new_game(new_game),
      .ssd0(ssd0), .ssd1(ssd1), .ssd2(ssd2), .ssd3(ssd3),
      .history0(history0), .history1(history1), .history2(history2), .history3(history3),
      .cursor(cursor), .round(round), .review_active(review_active),
      .fb_valid(fb_valid), .win(win), .lose(lose)
   );

   assign obs = {history3, history2, history1, history0, cursor, round,
                 review_active, fb_valid, win, lose};

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_g[i] = 0;
      m_cursor = 0; m_round = 0; m_view = 0;
      m_review = 0; m_fb = 0; m_win = 0; m_lose = 0; m_checking = 0; m_done = 0;
   endtask

   task automatic model_edge();
      bit fb_next;
      fb_next = 0;
      if (new_game) begin
         model_reset();
      end else if (m_checking) begin
         fb_next = 1;
         if (ssd0 == 2 && ssd1 == 2 && ssd2 == 2 && ssd3 == 2) begin
            m_win = 1; m_done = 1;
         end else if (m_round == MR - 1) begin
            m_lose = 1; m_done = 1;
         end else begin
            m_cursor = 0;
         end
         m_round++;
         m_checking = 0;
      end else if (btn_submit) begin
         if (!m_done) begin
            for (int i = 0; i < 4; i++) m_hist[m_round][i] = m_g[i];
            m_review = 0; m_checking = 1;
         end
      end else if (btn_up) begin
         if (!m_done) begin
            m_g[m_cursor] = (m_g[m_cursor] + 1) % NC;
            m_review = 0;
         end
      end else if (btn_next) begin
         if (!m_done) begin
            m_cursor = (m_cursor + 1) % 4;
            m_review = 0;
         end
      end else if (btn_review) begin
         if (m_round > 0) begin
            if (!m_review) begin m_review = 1; m_view = 0; end
            else if (m_view == m_round - 1) m_review = 0;
            else m_view++;
         end
      end
      m_fb = fb_next;
   endtask

   function automatic logic [21:0] exp_vec();
      int h[4];
      for (int i = 0; i < 4; i++) h[i] = m_review ? m_hist[m_view][i] : m_g[i];
      return {3'(h[3]), 3'(h[2]), 3'(h[1]), 3'(h[0]), 2'(m_cursor), 4'(m_round),
              m_review, m_fb, m_win, m_lose};
   endfunction

   task automatic tick();
      if (!rst_n) model_reset();
      else        model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit up, input bit nx, input bit sb, input bit rv, input bit ng);
      btn_up = up; btn_next = nx; btn_submit = sb; btn_review = rv; new_game = ng;
      tick();
      btn_up = 0; btn_next = 0; btn_submit = 0; btn_review = 0; new_game = 0;
   endtask

   task automatic set_ssd(input int a, input int b, input int c, input int d);
      ssd0 = 2'(a); ssd1 = 2'(b); ssd2 = 2'(c); ssd3 = 2'(d);
   endtask

   // Enter a guess starting with cursor at 0; ends with cursor back at 0.
   task automatic enter_guess(input int a0, input int a1, input int a2, input int a3);
      int tgt[4];
      tgt = '{a0, a1, a2, a3};
      for (int p = 0; p < 4; p++) begin
         while (m_g[p] != tgt[p]) press(1, 0, 0, 0, 0);
         press(0, 1, 0, 0, 0);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      tick(); tick();
      total++;
      if (obs !== 22'd0) begin
         bad++; $display("FAIL reset_state: got %h want %h", obs, 22'd0);
      end
      rst_n = 1;
      tick();
      total++;
      if (obs !== exp_vec()) begin
         bad++; $display("FAIL after_reset_idle: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_up_wrap();
      int seq[7];
      seq = '{1, 2, 3, 4, 5, 0, 1};
      press(0, 0, 0, 0, 1);
      for (int k = 0; k < 7; k++) begin
         press(1, 0, 0, 0, 0);
         total++;
         if (history0 !== 3'(seq[k]) || {history1, history2, history3} !== 9'd0 || cursor !== 2'd0) begin
            bad++;
            $display("FAIL up_wrap[%0d]: got h0=%0d h1..3=%h cur=%0d want h0=%0d h1..3=0 cur=0",
                     k, history0, {history1, history2, history3}, cursor, seq[k]);
         end
      end
   endtask

   task automatic test_win();
      press(0, 0, 0, 0, 1);
      enter_guess(1, 2, 3, 4);
      set_ssd(2, 2, 2, 2);
      press(0, 0, 1, 0, 0);
      total++;
      if (fb_valid !== 1'b0 || {history3, history2, history1, history0} !== {3'd4, 3'd3, 3'd2, 3'd1}) begin
         bad++; $display("FAIL win_check_cycle: got fb=%0d hist=%h want fb=0 hist=%h",
                         fb_valid, {history3, history2, history1, history0}, {3'd4, 3'd3, 3'd2, 3'd1});
      end
      tick();
      total++;
      if (fb_valid !== 1'b1 || win !== 1'b1 || lose !== 1'b0 || round !== 4'd1) begin
         bad++; $display("FAIL win_result: got fb=%0d win=%0d lose=%0d round=%0d want 1 1 0 1",
                         fb_valid, win, lose, round);
      end
      tick();
      total++;
      if (fb_valid !== 1'b0 || win !== 1'b1) begin
         bad++; $display("FAIL win_hold: got fb=%0d win=%0d want fb=0 win=1", fb_valid, win);
      end
      press(1, 0, 0, 0, 0);
      press(0, 1, 0, 0, 0);
      press(0, 0, 1, 0, 0);
      tick();
      total++;
      if ({history3, history2, history1, history0} !== {3'd4, 3'd3, 3'd2, 3'd1} || round !== 4'd1
          || fb_valid !== 1'b0) begin
         bad++; $display("FAIL done_ignores_edit: got hist=%h round=%0d fb=%0d want hist=%h round=1 fb=0",
                         {history3, history2, history1, history0}, round, fb_valid, {3'd4, 3'd3, 3'd2, 3'd1});
      end
      set_ssd(0, 0, 0, 0);
   endtask

   task automatic test_lose();
      press(0, 0, 0, 0, 1);
      set_ssd(1, 0, 0, 0);
      for (int r = 1; r <= MR; r++) begin
         press(1, 0, 0, 0, 0);
         press(0, 0, 1, 0, 0);
         tick();
         total++;
         if (round !== 4'(r) || win !== 1'b0 || lose !== ((r == MR) ? 1'b1 : 1'b0)
             || fb_valid !== 1'b1 || cursor !== 2'd0) begin
            bad++; $display("FAIL lose_round[%0d]: got round=%0d win=%0d lose=%0d fb=%0d cur=%0d want round=%0d win=0 lose=%0d fb=1 cur=0",
                            r, round, win, lose, fb_valid, cursor, r, (r == MR));
         end
      end
      press(0, 0, 1, 0, 0);
      tick();
      total++;
      if (round !== 4'd8 || lose !== 1'b1 || fb_valid !== 1'b0) begin
         bad++; $display("FAIL lose_hold: got round=%0d lose=%0d fb=%0d want 8 1 0", round, lose, fb_valid);
      end
      set_ssd(0, 0, 0, 0);
   endtask

   task automatic test_review();
      press(0, 0, 0, 0, 1);
      set_ssd(0, 0, 0, 0);
      for (int r = 0; r < 3; r++) begin
         press(1, 0, 0, 0, 0);
         press(0, 0, 1, 0, 0);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         press(0, 0, 0, 1, 0);
         total++;
         if (review_active !== 1'b1 || history0 !== 3'(k + 1) || {history1, history2, history3} !== 9'd0) begin
            bad++; $display("FAIL review_row[%0d]: got ra=%0d h0=%0d want ra=1 h0=%0d",
                            k, review_active, history0, k + 1);
         end
      end
      press(0, 0, 0, 1, 0);
      total++;
      if (review_active !== 1'b0 || history0 !== 3'd3) begin
         bad++; $display("FAIL review_exit: got ra=%0d h0=%0d want ra=0 h0=3", review_active, history0);
      end
   endtask

   task automatic test_priority();
      press(0, 0, 0, 0, 1);
      set_ssd(0, 1, 0, 0);
      press(1, 0, 0, 0, 0);
      press(1, 0, 1, 0, 0);
      total++;
      if (history0 !== 3'd1 || fb_valid !== 1'b0 || round !== 4'd0) begin
         bad++; $display("FAIL submit_over_up: got h0=%0d fb=%0d round=%0d want h0=1 fb=0 round=0",
                         history0, fb_valid, round);
      end
      press(1, 0, 0, 0, 0);
      total++;
      if (history0 !== 3'd1 || fb_valid !== 1'b1 || round !== 4'd1) begin
         bad++; $display("FAIL up_in_check: got h0=%0d fb=%0d round=%0d want h0=1 fb=1 round=1",
                         history0, fb_valid, round);
      end
      set_ssd(0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_check();
      press(0, 0, 0, 0, 1);
      press(1, 0, 0, 0, 0);
      press(1, 0, 0, 0, 0);
      press(0, 0, 1, 0, 0);
      #2 rst_n = 0;
      #1;
      model_reset();
      total++;
      if (obs !== 22'd0) begin
         bad++; $display("FAIL async_reset_mid_check: got %h want %h", obs, 22'd0);
      end
      tick();
      rst_n = 1;
      press(0, 1, 0, 0, 0);
      press(1, 0, 0, 0, 0);
      press(0, 0, 1, 0, 0);
      tick();
      total++;
      if (round !== 4'd1 || fb_valid !== 1'b1 || win !== 1'b0) begin
         bad++; $display("FAIL post_reset_round: got round=%0d fb=%0d win=%0d want 1 1 0", round, fb_valid, win);
      end
      press(0, 0, 0, 1, 0);
      total++;
      if (review_active !== 1'b1 || {history3, history2, history1, history0} !== {3'd0, 3'd0, 3'd1, 3'd0}) begin
         bad++; $display("FAIL post_reset_row0: got ra=%0d hist=%h want ra=1 hist=%h",
                         review_active, {history3, history2, history1, history0}, {3'd0, 3'd0, 3'd1, 3'd0});
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      press(0, 0, 0, 0, 1);
      for (int c = 0; c < 1500; c++) begin
         btn_up     = ($urandom_range(0, 3) == 0);
         btn_next   = ($urandom_range(0, 4) == 0);
         btn_submit = ($urandom_range(0, 5) == 0);
         btn_review = ($urandom_range(0, 3) == 0);
         new_game   = ($urandom_range(0, 90) == 0);
         if ($urandom_range(0, 4) == 0) set_ssd(2, 2, 2, 2);
         else set_ssd($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++;
            if (errs < 10) $display("FAIL random[%0d]: got %h want %h", c, obs, exp_vec());
            errs++;
         end
      end
      btn_up = 0; btn_next = 0; btn_submit = 0; btn_review = 0; new_game = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_up_wrap();
      test_win();
      test_lose();
      test_review();
      test_priority();
      test_reset_mid_check();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
